// File: rtl/ram_readout_dma.sv
// ram_readout_dma: on a CPU start, reads a block of bytes from the sample RAM in
// address order and pushes them to a downstream FIFO, with pipelined reads and credit backpressure.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start_transfer        one-cycle start strobe (IDLE only, length!=0)
//   abort                 stop issuing, drain in-flight reads, go idle
//   start_addr, length    block origin and byte count, sampled on start
//   busy, ready, aborted  status: in progress / done pulse / abort-done pulse
//   ram_addr, ram_rden    RAM read port; ram_q returns RD_LATENCY clocks later
//   fifo_d, fifo_wrreq    FIFO write port; fifo_usedw is the FIFO fill level
module ram_readout_dma #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_transfer,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              ready,
  output logic              aborted,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] fifo_d,
  output logic              fifo_wrreq,
  input  logic [USEDW_W-1:0] fifo_usedw
);

  localparam int CW = USEDW_W + 2;
  localparam logic [CW-1:0] LIMIT = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] rem_q, rem_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic abt_q, abt_d;
  logic ready_q, ready_d;
  logic aborted_q, aborted_d;
  logic credit;
  logic issue;
  logic wr;

  // Reads in flight are counted against the FIFO so that every
  // issued read is guaranteed a slot when its data arrives.
  assign credit = ({2'b00, fifo_usedw} + infl_q) < LIMIT;
  assign issue = (state_q == S_READ) && !abort && credit;
  assign wr = vld_q[RD_LATENCY-1];

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    abt_d = abt_q;
    ready_d = 1'b0;
    aborted_d = 1'b0;
    vld_d = vld_q << 1;
    vld_d[0] = issue;
    infl_d = infl_q + CW'(issue) - CW'(wr);
    unique case (state_q)
      S_IDLE: begin
        if (start_transfer && (length != '0)) begin
          addr_d = start_addr;
          rem_d = length;
          abt_d = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
        if (abort) begin
          abt_d = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave on the edge of the final write so the
        // done pulse lands one clock after that write.
        if (infl_d == '0) begin
          state_d = S_IDLE;
          ready_d = !abt_q;
          aborted_d = abt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      rem_q <= '0;
      infl_q <= '0;
      vld_q <= '0;
      abt_q <= 1'b0;
      ready_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      infl_q <= infl_d;
      vld_q <= vld_d;
      abt_q <= abt_d;
      ready_q <= ready_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign ready = ready_q;
  assign aborted = aborted_q;
  assign ram_addr = addr_q;
  assign ram_rden = issue;
  assign fifo_wrreq = wr;
  assign fifo_d = ram_q;

endmodule
